param_reg_file: RTL and testbench

Parametrised general-purpose register file that succeeds the fixed 8x32 normal register bank. It generalises data width and register count. It adds a synchronous reset, an optional hard-wired zero register, and write-to-read bypass. It adds a per-register pending-write scoreboard driven from the decode stage, and a branch-target read port that waits on pending writes. It sits between instruction decode (issue, reads, branch requests) and writeback (ALU or ID result).

---
 rtl/param_reg_file.sv | 143 ++++++++++++++
 tb/tb_param_reg_file.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_file.sv
// Parametrised register file with pending-write scoreboard, optional zero register,
// write-to-read bypass and a branch-target read port that waits on pending writes.
module param_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] reg1_val,
  output logic [DATA_W-1:0] reg2_val,
  output logic              reg1_busy,
  output logic              reg2_busy,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_value_alu,
  input  logic [DATA_W-1:0] write_value_id,
  input  logic              write_data_sel,
  input  logic              issue_enable,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [DATA_W-1:0] br_value,
  output logic              br_valid,
  output logic              br_busy
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic {IDLE, WAIT} brState_t;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  brState_t          r_state;
  brState_t          w_nextState;
  logic [ADDR_W-1:0] r_brAddr;
  logic [DATA_W-1:0] r_brValue;
  logic              r_brValid;

  logic [DATA_W-1:0] w_wdata;
  logic              w_wrEn;
  logic              w_issEn;
  logic [ADDR_W-1:0] w_rdAddr [3];
  logic [DATA_W-1:0] w_rdVal  [3];
  logic              w_rdBusy [3];
  logic              w_brLoad;
  logic [DATA_W-1:0] w_brData;
  logic              w_brLatch;

  assign w_wdata = write_data_sel ? write_value_alu : write_value_id;
  assign w_wrEn  = write_enable && !((ZERO_REG == 1) && (write_addr == '0));
  assign w_issEn = issue_enable && !((ZERO_REG == 1) && (issue_addr == '0));

  // Issue is applied after the write so a same-cycle reissue leaves the register busy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wrEn) begin
        r_regs[write_addr] <= w_wdata;
        r_busy[write_addr] <= 1'b0;
      end
      if (w_issEn) r_busy[issue_addr] <= 1'b1;
    end
  end

  assign w_rdAddr[0] = read_addr1;
  assign w_rdAddr[1] = read_addr2;
  assign w_rdAddr[2] = br_addr;

  // Shared view for both read ports and the branch lookup
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_rdVal[k]  = r_regs[w_rdAddr[k]];
      w_rdBusy[k] = r_busy[w_rdAddr[k]];
      if ((BYPASS == 1) && w_wrEn && (write_addr == w_rdAddr[k])) begin
        w_rdVal[k]  = w_wdata;
        w_rdBusy[k] = w_issEn && (issue_addr == w_rdAddr[k]);
      end
      if ((ZERO_REG == 1) && (w_rdAddr[k] == '0)) begin
        w_rdVal[k]  = '0;
        w_rdBusy[k] = 1'b0;
      end
    end
  end

  assign reg1_val  = w_rdVal[0];
  assign reg2_val  = w_rdVal[1];
  assign reg1_busy = w_rdBusy[0];
  assign reg2_busy = w_rdBusy[1];

  always_comb begin
    w_nextState = r_state;
    w_brLoad    = 1'b0;
    w_brData    = r_brValue;
    w_brLatch   = 1'b0;
    case (r_state)
      IDLE: begin
        if (br_req) begin
          if (!w_rdBusy[2]) begin
            w_brLoad = 1'b1;
            w_brData = w_rdVal[2];
          end else begin
            w_brLatch   = 1'b1;
            w_nextState = WAIT;
          end
        end
      end
      WAIT: begin
        // Waiting completes on the raw writeback, independent of the bypass setting
        if (write_enable && (write_addr == r_brAddr)) begin
          w_brLoad    = 1'b1;
          w_brData    = w_wdata;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_brAddr  <= '0;
      r_brValue <= '0;
      r_brValid <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_brValid <= w_brLoad;
      if (w_brLoad) r_brValue <= w_brData;
      if (w_brLatch) r_brAddr <= br_addr;
    end
  end

  assign br_value = r_brValue;
  assign br_valid = r_brValid;
  assign br_busy  = (r_state == WAIT);

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: three instances (default, no bypass, zero register)
// share one stimulus stream so each configuration is checked against the same steps.
module tb_param_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  read_addr1, read_addr2, write_addr, issue_addr, br_addr;
  logic        write_enable, write_data_sel, issue_enable, br_req;
  logic [31:0] write_value_alu, write_value_id;

  logic [31:0] aReg1, aReg2, aBrVal, bReg1, bReg2, bBrVal, zReg1, zReg2, zBrVal;
  logic        aBusy1, aBusy2, aBrValid, aBrBusy;
  logic        bBusy1, bBusy2, bBrValid, bBrBusy;
  logic        zBusy1, zBusy2, zBrValid, zBrBusy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  param_reg_file #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) uA (
    .clk(clk), .reset(reset), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .reg1_val(aReg1), .reg2_val(aReg2), .reg1_busy(aBusy1), .reg2_busy(aBusy2),
    .write_enable(write_enable), .write_addr(write_addr), .write_value_alu(write_value_alu),
    .write_value_id(write_value_id), .write_data_sel(write_data_sel),
    .issue_enable(issue_enable), .issue_addr(issue_addr), .br_req(br_req), .br_addr(br_addr),
    .br_value(aBrVal), .br_valid(aBrValid), .br_busy(aBrBusy));

  param_reg_file #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) uB (
    .clk(clk), .reset(reset), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .reg1_val(bReg1), .reg2_val(bReg2), .reg1_busy(bBusy1), .reg2_busy(bBusy2),
    .write_enable(write_enable), .write_addr(write_addr), .write_value_alu(write_value_alu),
    .write_value_id(write_value_id), .write_data_sel(write_data_sel),
    .issue_enable(issue_enable), .issue_addr(issue_addr), .br_req(br_req), .br_addr(br_addr),
    .br_value(bBrVal), .br_valid(bBrValid), .br_busy(bBrBusy));

  param_reg_file #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) uZ (
    .clk(clk), .reset(reset), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .reg1_val(zReg1), .reg2_val(zReg2), .reg1_busy(zBusy1), .reg2_busy(zBusy2),
    .write_enable(write_enable), .write_addr(write_addr), .write_value_alu(write_value_alu),
    .write_value_id(write_value_id), .write_data_sel(write_data_sel),
    .issue_enable(issue_enable), .issue_addr(issue_addr), .br_req(br_req), .br_addr(br_addr),
    .br_value(zBrVal), .br_valid(zBrValid), .br_busy(zBrBusy));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [31:0] alu,
                               input logic [31:0] id, input logic sel, input logic ie,
                               input logic [2:0] ia, input logic brq, input logic [2:0] bra,
                               input logic [2:0] ra1, input logic [2:0] ra2);
    write_enable = we; write_addr = wa; write_value_alu = alu; write_value_id = id;
    write_data_sel = sel; issue_enable = ie; issue_addr = ia; br_req = brq; br_addr = bra;
    read_addr1 = ra1; read_addr2 = ra2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1, 3'd5, 32'hFFFF_0000, 32'h0000_FFFF, 1, 1, 3'd5, 1, 3'd5, 0, 0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state: every register reads zero and idle
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'(a), 3'(a));
      checkOutput($sformatf("rst_val_r%0d", a), aReg1, 32'h0);
      checkOutput($sformatf("rst_busy1_r%0d", a), {31'b0, aBusy1}, 32'h0);
      checkOutput($sformatf("rst_busy2_r%0d", a), {31'b0, aBusy2}, 32'h0);
    end
    checkOutput("rst_brvalid", {31'b0, aBrValid}, 32'h0);
    checkOutput("rst_brbusy", {31'b0, aBrBusy}, 32'h0);
    checkOutput("rst_brvalue", aBrVal, 32'h0);

    // ALU write to r5, ID write to r2
    applyStimulus(1, 3'd5, 32'hDEAD_BEEF, 32'h1111_1111, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 0);
    checkOutput("alu_wr_r5_A", aReg1, 32'hDEAD_BEEF);
    checkOutput("alu_wr_r5_B", bReg1, 32'hDEAD_BEEF);
    applyStimulus(1, 3'd2, 32'hBAD0_BAD0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd5);
    checkOutput("id_wr_r2", aReg1, 32'h1234_5678);
    checkOutput("r5_kept", aReg2, 32'hDEAD_BEEF);

    // Same-cycle bypass on r3
    applyStimulus(1, 3'd3, 32'hA5A5_A5A5, 32'h0, 1, 0, 0, 0, 0, 3'd3, 0);
    checkOutput("bypass_A_val", aReg1, 32'hA5A5_A5A5);
    checkOutput("bypass_B_old", bReg1, 32'h0);
    checkOutput("bypass_A_busy", {31'b0, aBusy1}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0);
    checkOutput("bypass_B_after", bReg1, 32'hA5A5_A5A5);

    // Scoreboard on r4
    applyStimulus(0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 0, 3'd4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
    checkOutput("issue_r4_busy", {31'b0, aBusy2}, 32'h1);
    applyStimulus(1, 3'd4, 32'h44, 32'h0, 1, 1, 3'd4, 0, 0, 0, 3'd4);
    checkOutput("wr_iss_byp_busy", {31'b0, aBusy2}, 32'h1);
    checkOutput("wr_iss_byp_val", aReg2, 32'h44);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
    checkOutput("wr_iss_busy", {31'b0, aBusy2}, 32'h1);
    checkOutput("wr_iss_val", aReg2, 32'h44);
    applyStimulus(1, 3'd4, 32'h7, 32'h0, 1, 0, 0, 0, 0, 0, 3'd4);
    checkOutput("wr7_byp_busy_A", {31'b0, aBusy2}, 32'h0);
    checkOutput("wr7_byp_busy_B", {31'b0, bBusy2}, 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
    checkOutput("wr7_busy", {31'b0, aBusy2}, 32'h0);
    checkOutput("wr7_val", aReg2, 32'h7);

    // Branch hit on r6
    applyStimulus(1, 3'd6, 32'h100, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd6, 0, 0);
    checkOutput("brhit_pre_valid", {31'b0, aBrValid}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("brhit_valid", {31'b0, aBrValid}, 32'h1);
    checkOutput("brhit_value", aBrVal, 32'h100);
    checkOutput("brhit_busy", {31'b0, aBrBusy}, 32'h0);
    tick();
    checkOutput("brhit_valid_drop", {31'b0, aBrValid}, 32'h0);
    checkOutput("brhit_value_hold", aBrVal, 32'h100);

    // Branch wait on r1 with ignored requests while waiting
    applyStimulus(0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, (c != 1), 3'd6, 0, 0);
      checkOutput($sformatf("brwait_busy_c%0d", c), {31'b0, aBrBusy}, 32'h1);
      checkOutput($sformatf("brwait_valid_c%0d", c), {31'b0, aBrValid}, 32'h0);
      tick();
    end
    checkOutput("brwait_ignored_valid", {31'b0, aBrValid}, 32'h0);
    applyStimulus(1, 3'd1, 32'h2000, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("brwait_valid", {31'b0, aBrValid}, 32'h1);
    checkOutput("brwait_value_A", aBrVal, 32'h2000);
    checkOutput("brwait_value_B", bBrVal, 32'h2000);
    checkOutput("brwait_done_busy", {31'b0, aBrBusy}, 32'h0);
    tick();
    checkOutput("brwait_valid_drop", {31'b0, aBrValid}, 32'h0);

    // Zero register: write and issue to r0 together
    applyStimulus(1, 3'd0, 32'hFFFF_FFFF, 32'h0, 1, 1, 3'd0, 0, 0, 3'd0, 0);
    checkOutput("zero_byp_Z_val", zReg1, 32'h0);
    checkOutput("zero_byp_Z_busy", {31'b0, zBusy1}, 32'h0);
    checkOutput("zero_byp_A_val", aReg1, 32'hFFFF_FFFF);
    checkOutput("zero_byp_A_busy", {31'b0, aBusy1}, 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 0);
    checkOutput("zero_Z_val", zReg1, 32'h0);
    checkOutput("zero_Z_busy", {31'b0, zBusy1}, 32'h0);
    checkOutput("zero_A_val", aReg1, 32'hFFFF_FFFF);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("zero_br_Z_valid", {31'b0, zBrValid}, 32'h1);
    checkOutput("zero_br_Z_value", zBrVal, 32'h0);
    checkOutput("zero_br_A_busy", {31'b0, aBrBusy}, 32'h1);

    // Reset while the zero-register instance waits on r3
    applyStimulus(0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstwait_Z_busy_pre", {31'b0, zBrBusy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 0);
    checkOutput("rstwait_Z_busy", {31'b0, zBrBusy}, 32'h0);
    checkOutput("rstwait_A_busy", {31'b0, aBrBusy}, 32'h0);
    checkOutput("rstwait_Z_valid", {31'b0, zBrValid}, 32'h0);
    checkOutput("rstwait_Z_brval", zBrVal, 32'h0);
    checkOutput("rstwait_regs_clear", aReg1, 32'h0);
    applyStimulus(1, 3'd3, 32'h3333, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstwait_no_valid", {31'b0, zBrValid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
